// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Accept -> EXEC (ALU settles) -> RESP (one-cycle result pulse), one op per three cycles.
module alu_arbiter #(
   parameter int unsigned WORD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [2:0]            req0_op,
   input  logic [WORD_WIDTH-1:0] req0_a,
   input  logic [WORD_WIDTH-1:0] req0_b,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [2:0]            req1_op,
   input  logic [WORD_WIDTH-1:0] req1_a,
   input  logic [WORD_WIDTH-1:0] req1_b,
   output logic                  req1_ready,
   output logic                  rsp0_valid,
   output logic                  rsp1_valid,
   output logic [WORD_WIDTH-1:0] rsp_data,
   output logic [2:0]            alu_op,
   output logic [WORD_WIDTH-1:0] alu_in1,
   output logic [WORD_WIDTH-1:0] alu_in2,
   input  logic [WORD_WIDTH-1:0] alu_out,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state;
   logic   last;
   logic   owner;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state == IDLE && !reset) begin
         if (req0_valid && (!req1_valid || last)) begin
            req0_ready = 1'b1;
         end else if (req1_valid) begin
            req1_ready = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last       <= 1'b1;
         owner      <= 1'b0;
         alu_op     <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         rsp_data   <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready || req1_ready) begin
                  owner   <= req1_ready;
                  last    <= req1_ready;
                  alu_op  <= req1_ready ? req1_op : req0_op;
                  alu_in1 <= req1_ready ? req1_a  : req0_a;
                  alu_in2 <= req1_ready ? req1_b  : req0_b;
                  busy    <= 1'b1;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               rsp_data   <= alu_out;
               rsp0_valid <= ~owner;
               rsp1_valid <= owner;
               state      <= RESP;
            end
            RESP: begin
               rsp0_valid <= 1'b0;
               rsp1_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a cycle-level arbitration model predicts grants,
// queues expected responses, and a monitor checks every cycle against the DUT.
module tb_alu_arbiter;

   localparam int unsigned W = 16;
   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_MUL   = 3'd2;
   localparam logic [2:0] ALU_SLT   = 3'd3;
   localparam logic [2:0] ALU_SHIFT = 3'd4;

   logic         clk;
   logic         reset;
   logic         req0_valid, req1_valid;
   logic [2:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic         rsp0_valid, rsp1_valid;
   logic [W-1:0] rsp_data;
   logic [2:0]   alu_op;
   logic [W-1:0] alu_in1, alu_in2, alu_out;
   logic         busy;

   alu_arbiter #(.WORD_WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
      .busy(busy)
   );

   function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = '0;
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_MUL:   begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return p[W-1:0]; end
         ALU_SLT:   return {{(W-1){1'b0}}, (a < b)};
         ALU_SHIFT: return a << b;
         default:   return '0;
      endcase
   endfunction

   // Stand-in for the shared combinational ALU.
   always_comb alu_out = alu_fn(alu_op, alu_in1, alu_in2);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int compared = 0;
   int mism     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mism++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      int           owner;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      int           due;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   last_acc = -100;
   int   mlast    = 1;

   initial begin
      int   win;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            chk("reset_outputs",
                64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy,
                     rsp_data, alu_op, alu_in1, alu_in2}), 64'd0);
            mlast    = 1;
            last_acc = -100;
            exp_q.delete();
         end else begin
            win = -1;
            if (cyc >= last_acc + 3) begin
               if (req0_valid && req1_valid) win = 1 - mlast;
               else if (req0_valid)          win = 0;
               else if (req1_valid)          win = 1;
            end
            chk("ready", 64'({req1_ready, req0_ready}),
                64'((win == 1) ? 2'b10 : (win == 0) ? 2'b01 : 2'b00));
            chk("busy", 64'(busy), 64'((cyc > last_acc) && (cyc < last_acc + 3)));

            if (rsp0_valid || rsp1_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_owner", 64'({rsp1_valid, rsp0_valid}),
                      64'((e.owner == 1) ? 2'b10 : 2'b01));
                  chk("rsp_cycle", 64'(cyc), 64'(e.due));
                  chk("rsp_data", 64'(rsp_data), 64'(e.res));
                  chk("alu_inputs", 64'({alu_op, alu_in1, alu_in2}), 64'({e.op, e.a, e.b}));
               end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               e = exp_q.pop_front();
               chk("rsp_missing", 64'({rsp1_valid, rsp0_valid}),
                   64'((e.owner == 1) ? 2'b10 : 2'b01));
            end

            if (win >= 0) begin
               e.owner = win;
               e.op    = (win == 1) ? req1_op : req0_op;
               e.a     = (win == 1) ? req1_a  : req0_a;
               e.b     = (win == 1) ? req1_b  : req0_b;
               e.res   = alu_fn(e.op, e.a, e.b);
               e.due   = cyc + 2;
               exp_q.push_back(e);
               mlast    = win;
               last_acc = cyc;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   op_t sq0[$];
   op_t sq1[$];

   task automatic drive();
      req0_valid = (sq0.size() > 0);
      req1_valid = (sq1.size() > 0);
      if (sq0.size() > 0) begin req0_op = sq0[0].op; req0_a = sq0[0].a; req0_b = sq0[0].b; end
      if (sq1.size() > 0) begin req1_op = sq1[0].op; req1_a = sq1[0].a; req1_b = sq1[0].b; end
   endtask

   // Advances one cycle; a request leaves its queue only once it has been accepted.
   task automatic tick();
      logic a0, a1;
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0 && sq0.size() > 0) sq0.delete(0);
      if (a1 && sq1.size() > 0) sq1.delete(0);
      drive();
   endtask

   task automatic push(input int r, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
      op_t o;
      o = '{op: op, a: a, b: b};
      if (r == 0) sq0.push_back(o);
      else        sq1.push_back(o);
      drive();
   endtask

   task automatic push_rand(input int r);
      logic [2:0] op;
      op = 3'($urandom_range(0, 4));
      push(r, op, W'($urandom), (op == ALU_SHIFT) ? W'($urandom_range(0, 20)) : W'($urandom));
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      sq0.delete();
      sq1.delete();
      drive();
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic wait_empty(input int maxc);
      int n;
      n = 0;
      while ((sq0.size() > 0 || sq1.size() > 0) && n < maxc) begin
         tick();
         n++;
      end
      chk("accept_timeout", 64'(sq0.size() + sq1.size()), 64'd0);
   endtask

   task automatic drain(input int maxc);
      wait_empty(maxc);
      repeat (4) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      @(posedge clk);
      #1;
      do_reset(3);

      // basic add
      push(0, ALU_ADD, 16'd3, 16'd4);
      drain(10);

      // simultaneous requests from reset
      do_reset(2);
      push(0, ALU_SUB, 16'd10, 16'd3);
      push(1, ALU_MUL, 16'd5, 16'd6);
      drain(20);

      // fairness: both held valid continuously
      do_reset(2);
      for (int i = 0; i < 4; i++) begin
         push(0, ALU_ADD, W'(i), 16'd100);
         push(1, ALU_SUB, 16'd100, W'(i));
      end
      drain(40);

      // width boundaries
      push(0, ALU_ADD,   16'hFFFF, 16'h0001);
      push(0, ALU_MUL,   16'h0100, 16'h0100);
      push(0, ALU_SLT,   16'd2,    16'd5);
      push(0, ALU_SLT,   16'd5,    16'd2);
      push(0, ALU_SHIFT, 16'd1,    16'd4);
      drain(30);

      // reset during EXEC, then a tie must go to requester 0
      push(1, ALU_ADD, 16'd1, 16'd1);
      wait_empty(10);
      do_reset(2);
      push(0, ALU_ADD, 16'd2, 16'd2);
      push(1, ALU_ADD, 16'd3, 16'd3);
      drain(20);

      // withdrawn request while busy, late request during RESP
      push(1, ALU_ADD, 16'd100, 16'd23);
      wait_empty(10);
      req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 16'd9; req0_b = 16'd9;
      tick();
      push(1, ALU_SUB, 16'd50, 16'd8);
      drain(20);

      // random traffic with withdrawals and occasional reset
      for (int i = 0; i < 400; i++) begin
         if (sq0.size() == 0 && $urandom_range(0, 2) == 0) push_rand(0);
         if (sq1.size() == 0 && $urandom_range(0, 2) == 0) push_rand(1);
         if (sq0.size() > 0 && $urandom_range(0, 15) == 0) sq0.delete(0);
         if (sq1.size() > 0 && $urandom_range(0, 15) == 0) sq1.delete(0);
         drive();
         if ($urandom_range(0, 149) == 0) do_reset(2);
         tick();
      end
      drain(60);

      chk("leftover_expected", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters (e.g. the execute stage and the address/branch unit). It arbitrates round-robin, registers the granted operation onto the ALU inputs, allows one full cycle for the ALU to settle, then captures the result and returns it to the winner. Throughput is one operation per three cycles, with a fixed, deterministic latency.

## Interface
- WORD_WIDTH, 16, datapath width; matches the shared parameter set.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  3  ALU opcode from the shared parameter set (ALU_ADD … ALU_SHIFT).
- req0_a, req0_b  in  WORD_WIDTH  operands (in1, in2).
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as the requester 0 signals.
- rsp0_valid  out  1  one-cycle pulse: result for requester 0 is on rsp_data.
- rsp1_valid  out  1  one-cycle pulse: result for requester 1 is on rsp_data.
- rsp_data  out  WORD_WIDTH  captured ALU result; shared by both requesters.
- alu_op  out  3  registered opcode to the ALU.
- alu_in1, alu_in2  out  WORD_WIDTH  registered operands to the ALU.
- alu_out  in  WORD_WIDTH  ALU result.
- busy  out  1  high in EXEC and RESP.

## Operation
- **States:** IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:** select a winner.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
  - reqN_ready is combinational: high only for the winner, only in IDLE, never both at once, forced 0 while reset is high.
- **Accept:** on a cycle with valid && ready:
  - latch op/a/b into alu_op/alu_in1/alu_in2;
  - record `owner` and update `last` to the owner;
  - go to EXEC.
- **EXEC:** ALU inputs are held stable for the whole cycle. At the end of the cycle, capture alu_out into rsp_data and go to RESP.
- **RESP:** rspN_valid is high for owner N for exactly one cycle. There is no backpressure; the requester must take the result. Go to IDLE.
- **Output holding:**
  - alu_op/alu_in1/alu_in2 hold their last values until the next accept.
  - rsp_data holds until the next capture.
- **Arithmetic:** the block passes operands and results through unmodified; all width behaviour belongs to the ALU.
  - ADD/SUB wrap modulo 2^WORD_WIDTH.
  - MUL returns the low WORD_WIDTH bits.
  - SLT is an unsigned compare returning 0 or 1, zero-extended.
  - SHIFT is a logical left shift, truncated.
- **Requests while busy:** a valid asserted while busy gets ready=0. The requester holds valid and operands until ready.
- **Withdrawn requests:** a requester may drop valid before ready; no operation is issued for it.
- **Reset in any state:**
  - immediately return to IDLE and set `last`=1;
  - clear alu_op, alu_in1, alu_in2, rsp_data, rsp0_valid, rsp1_valid and busy to 0;
  - the in-flight operation is discarded with no response.

## Timing
- **Reset values:** every output is 0; readies are 0 during reset.
- **Latency:** accept in cycle T → EXEC in T+1 → rspN_valid and valid rsp_data in T+2.
- The next accept is possible in cycle T+3, at earliest.
- rsp_data is valid only in the rsp_valid cycle for correctness checks. It still holds its value afterwards.
- The ALU path has one full cycle from the registered inputs to the capture.
- A contested pair of requests: the second requester's ready is high in T+3 and its response arrives in T+5.

## Test plan
- **Basic ADD:** reset; req0 ADD a=3 b=4 held valid → req0_ready in cycle 0; rsp0_valid only in cycle 2 with rsp_data=7; busy high in cycles 1–2; rsp1_valid stays 0.
- **Simultaneous requests:** req0 SUB 10,3 and req1 MUL 5,6 both valid in cycle 0 → req0 granted first (rsp0_valid cycle 2, data 7); req1_ready in cycle 3; rsp1_valid cycle 5, data 30.
- **Fairness:** both requesters held valid continuously for 4 operations → grant order 0,1,0,1; readies never high together; no ready while busy.
- **Width boundaries:** ADD 0xFFFF+1 → 0x0000; MUL 0x0100*0x0100 → 0x0000; SLT 2,5 → 1; SLT 5,2 → 0; SHIFT 1,4 → 0x0010.
- **Reset mid-operation:** assert reset during EXEC of req1 ADD 1,1 → no rsp1_valid; all outputs 0 immediately. After release, a tie on both requesters grants requester 0 first.
- **Withdrawn / late requests:** req0 valid for one cycle while busy, then dropped → never accepted, no response. req1 asserting valid during RESP → accepted in the following IDLE cycle.
